sysarray_seq: RTL and testbench
===============================

SYSARRAY_SEQ -- requirements
Module: sysarray_seq

Interface
- REQ-001: Parameter WL, default 32, data word width in bits.
- REQ-002: Parameter NUM, default 16, array edge (lanes per side).
- REQ-003: Parameter KW, default 8, width of depth counter and buffer addresses.
- REQ-004: clk  input  1  single clock; all logic on rising edge.
- REQ-005: rst  input  1  synchronous, active-high reset.
- REQ-006: ena  input  1  global advance enable; 0 freezes all state and outputs.
- REQ-007: start  input  1  one-cycle request to run one tile pass.
- REQ-008: kdepth  input  KW  accumulation depth K, sampled on accepted start.
- REQ-009: busy  output  1  high from accepted start until the done cycle inclusive.
- REQ-010: done  output  1  one-cycle completion pulse.
- REQ-011: wbuf_rd / fbuf_rd  output  1 each  weight / feature buffer read strobes.
- REQ-012: wbuf_addr / fbuf_addr  output  KW each  buffer read addresses.
- REQ-013: wbuf_data / fbuf_data  input  WL*NUM each  buffer read data, 1-cycle read latency.
- REQ-014: weightvalue / featurevalue  output  WL*NUM each  skewed lane data to the array edges.
- REQ-015: weigthvalid / featurevalid  output  NUM each  per-lane valid to the array.
- REQ-016: weigthend / featureend  output  NUM each  per-lane last-element flag to the array.
- REQ-017: resultvalid  input  NUM*NUM  per-PE result-valid flags from the array.

Function
- REQ-018: FSM states IDLE, FEED, DRAIN, DONE; all transitions and counters advance only when ena=1.
- REQ-019: IDLE: start=1 with kdepth>0 latches K, clears k counter, goes to FEED.
- REQ-020: IDLE: start=1 with kdepth=0 goes directly to DONE; no buffer reads, no valids issued.
- REQ-021: start while not IDLE is ignored; K cannot change mid-pass.
- REQ-022: FEED: each cycle assert wbuf_rd=fbuf_rd=1, wbuf_addr=fbuf_addr=k, k increments; after issuing k=K-1, go to DRAIN.
- REQ-023: Read issued in cycle t: lane-i slice of returned data (bits WL*(i+1)-1:WL*i) appears on lane i outputs at cycle t+1+i (per-lane skew of i cycles, both edges).
- REQ-024: Lane i valid is high exactly K consecutive cycles, for cycles F+1+i .. F+K+i, where F = first FEED cycle.
- REQ-025: Lane i end is high only with the element from address K-1, i.e. in cycle F+K+i.
- REQ-026: Lane value outputs are zero whenever the matching lane valid is low.
- REQ-027: Skew implemented as registered delay chains (0..NUM-1 stages per lane); chains hold when ena=0.
- REQ-028: DRAIN: go to DONE when all NUM*NUM resultvalid bits are 1 and all skew chains are empty.
- REQ-029: DRAIN timeout: if resultvalid is not all ones within K+3*NUM cycles of entering DRAIN, go to DONE anyway.
- REQ-030: DONE: done=1 for exactly one cycle, then IDLE; a start in the DONE cycle is ignored.
- REQ-031: busy=1 in FEED, DRAIN, DONE; 0 in IDLE.
- REQ-032: Read strobes are 0 outside FEED; addresses hold last value outside FEED.

Reset
- REQ-033: rst=1 (sampled regardless of ena) forces IDLE and clears k, K, skew chains and DRAIN timer.
- REQ-034: During/after reset: busy, done, all rd strobes, valids, ends, lane values, addresses = 0.
- REQ-035: Reset mid-FEED or mid-DRAIN aborts the pass; no done pulse is produced for it.

Verification
- REQ-036: NUM=4, K=3, start at cycle 0 -> reads at addr 0,1,2 in cycles 1-3; lane 3 valid cycles 5-7, end at 7.
- REQ-037: kdepth=0, start -> no rd strobes, done pulses 1 cycle later, busy high that cycle only.
- REQ-038: ena held 0 for 5 cycles mid-FEED -> outputs frozen, resumed sequence identical to the ena=1 run except shifted 5 cycles.
- REQ-039: resultvalid never all ones -> done at DRAIN entry + K+3*NUM cycles.
- REQ-040: rst asserted in DRAIN -> next cycle all outputs 0, state IDLE, no done; a new start runs a full pass.
- REQ-041: start pulsed during FEED and in DONE -> ignored, exactly one done per accepted start.

Source files
------------

// File: rtl/sysarray_seq.sv
// rtl/sysarray_seq.sv - tile sequencer: buffer reads, per-lane skewed feed and drain/done control for a NUM x NUM systolic array
module sysarray_seq #(
  parameter int WL  = 32,
  parameter int NUM = 16,
  parameter int KW  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                start,
  input  logic [KW-1:0]       kdepth,
  output logic                busy,
  output logic                done,
  output logic                wbuf_rd,
  output logic                fbuf_rd,
  output logic [KW-1:0]       wbuf_addr,
  output logic [KW-1:0]       fbuf_addr,
  input  logic [WL*NUM-1:0]   wbuf_data,
  input  logic [WL*NUM-1:0]   fbuf_data,
  output logic [WL*NUM-1:0]   weightvalue,
  output logic [WL*NUM-1:0]   featurevalue,
  output logic [NUM-1:0]      weigthvalid,
  output logic [NUM-1:0]      featurevalid,
  output logic [NUM-1:0]      weigthend,
  output logic [NUM-1:0]      featureend,
  input  logic [NUM*NUM-1:0]  resultvalid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int TW = KW + $clog2(3 * NUM + 1) + 1;

  logic [1:0]        state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [KW-1:0]     kdep_q, kdep_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [TW-1:0]     tmr_lim;
  logic [NUM-1:0]    vld_q;
  logic [NUM-1:0]    end_q;
  logic              feed;
  logic              last_rd;
  logic              ena_prev_q;
  logic [WL*NUM-1:0] wraw, fraw;
  logic [WL*NUM-1:0] wcap_q, fcap_q;

  assign feed    = (state_q == S_FEED);
  assign last_rd = feed && (k_q == kdep_q - KW'(1));
  assign tmr_lim = TW'(kdep_q) + TW'(3 * NUM - 1);

  // Read data that lands during a frozen cycle belongs to a read the pipeline has
  // not consumed yet; replay the last word captured while the pipe was advancing.
  assign wraw = ena_prev_q ? wbuf_data : wcap_q;
  assign fraw = ena_prev_q ? fbuf_data : fcap_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    kdep_d  = kdep_q;
    tmr_d   = tmr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (kdepth != '0) begin
            kdep_d  = kdepth;
            k_d     = '0;
            state_d = S_FEED;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FEED: begin
        if (last_rd) begin
          tmr_d   = '0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DRAIN: begin
        tmr_d = tmr_q + TW'(1);
        if (((&resultvalid) && (vld_q == '0)) || (tmr_q == tmr_lim)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      kdep_q     <= '0;
      tmr_q      <= '0;
      vld_q      <= '0;
      end_q      <= '0;
      ena_prev_q <= 1'b0;
      wcap_q     <= '0;
      fcap_q     <= '0;
    end else begin
      ena_prev_q <= ena;
      wcap_q     <= wraw;
      fcap_q     <= fraw;
      if (ena) begin
        state_q <= state_d;
        k_q     <= k_d;
        kdep_q  <= kdep_d;
        tmr_q   <= tmr_d;
        vld_q   <= (vld_q << 1) | NUM'(feed);
        end_q   <= (end_q << 1) | NUM'(last_rd);
      end
    end
  end

  // Lane i sees its data i registers after lane 0, matching the valid/end shift.
  for (genvar i = 0; i < NUM; i++) begin : g_lane
    logic [WL-1:0] wlane, flane;
    if (i == 0) begin : g_direct
      assign wlane = wraw[WL-1:0];
      assign flane = fraw[WL-1:0];
    end else begin : g_chain
      logic [WL-1:0] wch_q [i];
      logic [WL-1:0] fch_q [i];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < i; j++) begin
            wch_q[j] <= '0;
            fch_q[j] <= '0;
          end
        end else if (ena) begin
          wch_q[0] <= wraw[WL*i +: WL];
          fch_q[0] <= fraw[WL*i +: WL];
          for (int j = 1; j < i; j++) begin
            wch_q[j] <= wch_q[j-1];
            fch_q[j] <= fch_q[j-1];
          end
        end
      end
      assign wlane = wch_q[i-1];
      assign flane = fch_q[i-1];
    end
    assign weightvalue[WL*i +: WL]  = vld_q[i] ? wlane : '0;
    assign featurevalue[WL*i +: WL] = vld_q[i] ? flane : '0;
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign wbuf_rd      = feed;
  assign fbuf_rd      = feed;
  assign wbuf_addr    = k_q;
  assign fbuf_addr    = k_q;
  assign weigthvalid  = vld_q;
  assign featurevalid = vld_q;
  assign weigthend    = end_q;
  assign featureend   = end_q;

endmodule

// File: tb/tb_sysarray_seq.sv
// tb/tb_sysarray_seq.sv - scoreboard bench for sysarray_seq in effective (enabled) cycle time
module tb_sysarray_seq;
  localparam int WL  = 16;
  localparam int NUM = 4;
  localparam int KW  = 8;
  localparam int M_ALL  = 0;
  localparam int M_TMO  = 1;
  localparam int M_LATE = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                ena = 1'b1;
  logic                start = 1'b0;
  logic [KW-1:0]       kdepth = '0;
  logic                busy, done, wbuf_rd, fbuf_rd;
  logic [KW-1:0]       wbuf_addr, fbuf_addr;
  logic [WL*NUM-1:0]   wbuf_data = '0;
  logic [WL*NUM-1:0]   fbuf_data = '0;
  logic [WL*NUM-1:0]   weightvalue, featurevalue;
  logic [NUM-1:0]      weigthvalid, featurevalid, weigthend, featureend;
  logic [NUM*NUM-1:0]  resultvalid = '0;

  sysarray_seq #(.WL(WL), .NUM(NUM), .KW(KW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .kdepth(kdepth),
    .busy(busy), .done(done), .wbuf_rd(wbuf_rd), .fbuf_rd(fbuf_rd),
    .wbuf_addr(wbuf_addr), .fbuf_addr(fbuf_addr),
    .wbuf_data(wbuf_data), .fbuf_data(fbuf_data),
    .weightvalue(weightvalue), .featurevalue(featurevalue),
    .weigthvalid(weigthvalid), .featurevalid(featurevalid),
    .weigthend(weigthend), .featureend(featureend),
    .resultvalid(resultvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            lane;
    int            ecyc;
    logic [WL-1:0] w;
    logic [WL-1:0] f;
    logic          last;
  } item_t;

  item_t         sbq[$];
  int            total = 0;
  int            bad = 0;
  int            ecyc = 0;
  bit            rst_edge = 1'b0;
  int            salt = 0;
  bit            pass_act = 1'b0;
  int            p_f, p_k, p_done, p_mode, p_late;
  logic [KW-1:0] exp_addr = '0;

  function automatic logic [WL-1:0] mkword(logic [3:0] tg, int s, int a, int i);
    logic [3:0] s4, a4, i4;
    s4 = 4'(s);
    a4 = 4'(a);
    i4 = 4'(i);
    return {tg, s4, a4, i4};
  endfunction

  function automatic logic [WL*NUM-1:0] mkvec(logic [3:0] tg, int s, int a);
    logic [WL*NUM-1:0] v;
    for (int i = 0; i < NUM; i++) v[WL*i +: WL] = mkword(tg, s, a, i);
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s e=%0d got=%0h exp=%0h", tag, ecyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Effective time only advances on enabled, non-reset edges; reset drops all expectations.
  always @(posedge clk) begin
    if (rst) begin
      rst_edge = 1'b1;
      sbq.delete();
      pass_act = 1'b0;
      exp_addr = '0;
    end else begin
      rst_edge = 1'b0;
      if (ena) ecyc++;
    end
  end

  // Buffer model: one-cycle read latency, garbage when not read.
  logic          rd_w, rd_f;
  logic [KW-1:0] ad_w, ad_f;
  always @(negedge clk) begin
    rd_w = wbuf_rd; ad_w = wbuf_addr;
    rd_f = fbuf_rd; ad_f = fbuf_addr;
  end
  always @(posedge clk) begin
    #1;
    wbuf_data = rd_w ? mkvec(4'h1, salt, int'(ad_w)) : {$urandom, $urandom};
    fbuf_data = rd_f ? mkvec(4'h2, salt, int'(ad_f)) : {$urandom, $urandom};
  end

  int            m_e;
  bit            in_feed, ev;
  logic [WL-1:0] ew, ef;
  logic          el;
  always @(negedge clk) begin
    if (!(rst && !rst_edge)) begin
      m_e = ecyc;
      while (sbq.size() > 0 && sbq[0].ecyc < m_e) void'(sbq.pop_front());
      if (pass_act && m_e > p_done) pass_act = 1'b0;
      in_feed = pass_act && p_k > 0 && m_e >= p_f && m_e <= p_f + p_k - 1;
      if (in_feed) exp_addr = KW'(m_e - p_f);
      check("busy", busy, pass_act && m_e >= p_f && m_e <= p_done);
      check("done", done, pass_act && m_e == p_done);
      check("wrd", wbuf_rd, in_feed);
      check("frd", fbuf_rd, in_feed);
      check("waddr", wbuf_addr, exp_addr);
      check("faddr", fbuf_addr, exp_addr);
      for (int i = 0; i < NUM; i++) begin
        ev = 1'b0; ew = '0; ef = '0; el = 1'b0;
        for (int j = 0; j < sbq.size(); j++) begin
          if (sbq[j].ecyc == m_e && sbq[j].lane == i) begin
            ev = 1'b1; ew = sbq[j].w; ef = sbq[j].f; el = sbq[j].last;
          end
        end
        check($sformatf("wvld%0d", i), weigthvalid[i], ev);
        check($sformatf("fvld%0d", i), featurevalid[i], ev);
        check($sformatf("wend%0d", i), weigthend[i], el);
        check($sformatf("fend%0d", i), featureend[i], el);
        check($sformatf("wval%0d", i), weightvalue[WL*i +: WL], ew);
        check($sformatf("fval%0d", i), featurevalue[WL*i +: WL], ef);
      end
    end
  end

  task automatic launch(input int k, input int mode, input logic [NUM*NUM-1:0] pat);
    item_t it;
    salt++;
    kdepth = KW'(k);
    start = 1'b1;
    resultvalid = (mode == M_ALL) ? '1 : ((mode == M_LATE) ? '0 : pat);
    p_f = ecyc + 1;
    p_k = k;
    p_mode = mode;
    p_late = p_f + k + NUM + 3;
    if (k == 0)             p_done = p_f;
    else if (mode == M_ALL) p_done = p_f + k + NUM + 1;
    else if (mode == M_TMO) p_done = p_f + 2 * k + 3 * NUM;
    else                    p_done = p_late + 1;
    pass_act = 1'b1;
    for (int t = 0; t <= k + NUM - 2; t++) begin
      for (int i = 0; i < NUM; i++) begin
        if (t - i >= 0 && t - i < k) begin
          it.lane = i;
          it.ecyc = p_f + 1 + t;
          it.w    = mkword(4'h1, salt, t - i, i);
          it.f    = mkword(4'h2, salt, t - i, i);
          it.last = (t - i == k - 1);
          sbq.push_back(it);
        end
      end
    end
    tick();
    start = 1'b0;
    kdepth = KW'($urandom_range(1, 255));
  endtask

  task automatic wait_pass();
    for (int n = 0; n < 600 && ecyc <= p_done; n++) begin
      if (p_mode == M_LATE && ecyc == p_late) resultvalid = '1;
      tick();
    end
    check("pass_end", ecyc > p_done, 1);
  endtask

  logic [NUM*NUM-1:0] part;
  initial begin
    part = '1;
    part[5] = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    launch(3, M_ALL, '0);     wait_pass();
    launch(0, M_ALL, '0);     wait_pass();
    launch(5, M_TMO, '0);     wait_pass();
    launch(2, M_TMO, part);   wait_pass();
    launch(4, M_LATE, '0);    wait_pass();

    // freeze mid-FEED
    launch(6, M_ALL, '0);
    repeat (2) tick();
    ena = 1'b0;
    repeat (5) tick();
    ena = 1'b1;
    wait_pass();

    // starts while busy and in the DONE cycle must be ignored
    launch(4, M_ALL, '0);
    tick();
    start = 1'b1; kdepth = 8'd7;
    tick();
    start = 1'b0;
    for (int n = 0; n < 600 && ecyc < p_done; n++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_pass();
    repeat (6) tick();

    // reset in DRAIN aborts, then a fresh pass runs to completion
    launch(3, M_TMO, '0);
    for (int n = 0; n < 600 && ecyc < p_f + p_k + 2; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    launch(3, M_ALL, '0);     wait_pass();

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog e=%0d", ecyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
